// File: rtl/intr_ctrl.sv
// Interrupt front-end: input synchroniser, sticky edge-pending register, mask and a
// one-deep service FSM. Define INTC_LEVEL_TRIG_EN for level-sensitive pending instead.
module intr_ctrl #(
  parameter int NIRQ        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic [NIRQ-1:0] irq_in,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_wdata,
  input  logic            eoi,
  input  logic            int_ack,
  input  logic [2:0]      vec,
  output logic [NIRQ-1:0] intr,
  output logic [NIRQ-1:0] pending,
  output logic [NIRQ-1:0] mask,
  output logic            in_service
);

  typedef enum logic {IDLE, SERVICE} state_e;

  state_e          state_q;
  logic            in_service_q;
  logic [NIRQ-1:0] sync_q [SYNC_STAGES];
  logic [NIRQ-1:0] pending_q, pending_d;
  logic [NIRQ-1:0] mask_q, mask_d;
  logic [NIRQ-1:0] ack_sel;
  logic [NIRQ-1:0] s_line;
  logic            valid_ack;

  assign s_line = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!clrn) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Lines beyond NIRQ never decode, so an out-of-range vec selects nothing.
  always_comb begin
    ack_sel = '0;
    for (int i = 0; i < NIRQ; i++) ack_sel[i] = int_ack && (vec == 3'(i));
  end

  assign valid_ack = (state_q == IDLE) && (|(ack_sel & pending_q & ~mask_q));

`ifdef INTC_LEVEL_TRIG_EN
  assign pending_d = s_line;
`else
  logic [NIRQ-1:0] s_dly_q;
  logic [NIRQ-1:0] rise;

  always_ff @(posedge clk) begin
    if (!clrn) s_dly_q <= '0;
    else       s_dly_q <= s_line;
  end

  assign rise = s_line & ~s_dly_q;

  // A fresh edge wins over the clear in the same cycle.
  assign pending_d = (pending_q & ~(valid_ack ? ack_sel : '0)) | rise;
`endif

  assign mask_d = mask_we ? mask_wdata : mask_q;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      pending_q <= '0;
      mask_q    <= '1;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  // eoi takes precedence over any ack seen while in service.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q      <= IDLE;
      in_service_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_ack) begin
            state_q      <= SERVICE;
            in_service_q <= 1'b1;
          end
        end
        SERVICE: begin
          if (eoi) begin
            state_q      <= IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign intr       = (state_q == IDLE) ? (pending_q & ~mask_q) : '0;
  assign pending    = pending_q;
  assign mask       = mask_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a cycle-level behavioural model.
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       clrn;
  logic [7:0] irq_in;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       eoi;
  logic       int_ack;
  logic [2:0] vec;
  logic [7:0] intr;
  logic [7:0] pending;
  logic [7:0] mask;
  logic       in_service;

  int checks   = 0;
  int failures = 0;

  // Model: history of irq_in samples at past posedges, plus the architectural state.
  logic [7:0] hist [3];
  logic [7:0] mPend;
  logic [7:0] mMask;
  logic       mSvc;

  intr_ctrl dut (
    .clk(clk), .clrn(clrn), .irq_in(irq_in), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .eoi(eoi), .int_ack(int_ack), .vec(vec),
    .intr(intr), .pending(pending), .mask(mask), .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference rules applied once per posedge using the inputs presented for that edge.
  task automatic modelEdge();
    logic       validAck;
    logic [7:0] sNow, rise;
    if (!clrn) begin
      for (int k = 0; k < 3; k++) hist[k] = 8'h00;
      mPend = 8'h00;
      mMask = 8'hFF;
      mSvc  = 1'b0;
      return;
    end
    sNow     = hist[1];
    rise     = hist[1] & ~hist[2];
    validAck = int_ack && !mSvc && mPend[vec] && !mMask[vec];
`ifdef INTC_LEVEL_TRIG_EN
    mPend = sNow;
`else
    if (validAck) mPend[vec] = 1'b0;
    mPend = mPend | rise;
`endif
    if (mSvc && eoi)   mSvc = 1'b0;
    else if (validAck) mSvc = 1'b1;
    if (mask_we) mMask = mask_wdata;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = irq_in;
  endtask

  task automatic applyStimulus(input logic r, input logic [7:0] irq, input logic mwe,
                               input logic [7:0] mwd, input logic e, input logic ack,
                               input logic [2:0] v);
    clrn = r; irq_in = irq; mask_we = mwe; mask_wdata = mwd;
    eoi = e; int_ack = ack; vec = v;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("model_pending", pending, mPend);
    checkOutput("model_mask", mask, mMask);
    checkOutput("model_insvc", {7'b0, in_service}, {7'b0, mSvc});
    checkOutput("model_intr", intr, mSvc ? 8'h00 : (mPend & ~mMask));
    #3;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) hist[k] = 8'h00;
    mPend = 0; mMask = 8'hFF; mSvc = 0;
    @(negedge clk);

    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_intr", intr, 8'h00);
    checkOutput("reset_pending", pending, 8'h00);
    checkOutput("reset_mask", mask, 8'hFF);
    checkOutput("reset_insvc", {7'b0, in_service}, 8'h00);

`ifndef INTC_LEVEL_TRIG_EN
    applyStimulus(1, 0, 1, 8'h00, 0, 0, 0);
    applyStimulus(1, 8'h08, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("basic_not_yet", pending, 8'h00);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("basic_pending", pending, 8'h08);
    checkOutput("basic_intr", intr, 8'h08);
    applyStimulus(1, 0, 0, 0, 0, 1, 3);
    checkOutput("ack_pending", pending, 8'h00);
    checkOutput("ack_insvc", {7'b0, in_service}, 8'h01);
    checkOutput("ack_intr", intr, 8'h00);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkOutput("eoi_insvc", {7'b0, in_service}, 8'h00);

    applyStimulus(1, 8'h01, 1, 8'h01, 0, 0, 0);
    idle(2);
    checkOutput("mask_pending", pending, 8'h01);
    checkOutput("mask_intr", intr, 8'h00);
    applyStimulus(1, 0, 1, 8'h00, 0, 0, 0);
    checkOutput("unmask_intr", intr, 8'h01);
    applyStimulus(1, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);

    applyStimulus(1, 8'h04, 0, 0, 0, 0, 0);
    idle(2);
    applyStimulus(1, 8'h04, 0, 0, 0, 0, 0);
    idle(1);
    applyStimulus(1, 0, 0, 0, 0, 1, 2);
    checkOutput("setwin_pending", pending, 8'h04);
    checkOutput("setwin_insvc", {7'b0, in_service}, 8'h01);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 2);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);

    applyStimulus(1, 8'h02, 0, 0, 0, 0, 0);
    idle(2);
    applyStimulus(1, 0, 0, 0, 0, 1, 1);
    applyStimulus(1, 8'h20, 0, 0, 0, 0, 0);
    idle(2);
    checkOutput("svc_edge_pending", pending, 8'h20);
    checkOutput("svc_edge_intr", intr, 8'h00);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkOutput("svc_eoi_intr", intr, 8'h20);

    applyStimulus(1, 0, 0, 0, 0, 1, 5);
    applyStimulus(1, 8'h30, 0, 0, 0, 0, 0);
    idle(2);
    checkOutput("midsvc_pending", pending, 8'h30);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("midsvc_rst_pend", pending, 8'h00);
    checkOutput("midsvc_rst_insvc", {7'b0, in_service}, 8'h00);
    applyStimulus(1, 0, 0, 0, 0, 1, 4);
    checkOutput("post_rst_ack", {7'b0, in_service}, 8'h00);
`endif

    for (int n = 0; n < 1500; n++) begin
      logic [7:0] irq;
      logic       ack, r;
      logic [2:0] v;
      irq = irq_in;
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 5) == 0) irq[b] = ~irq[b];
      r   = ($urandom_range(0, 250) != 0);
      v   = 3'($urandom_range(0, 7));
      ack = ($urandom_range(0, 3) == 0);
      if (mPend[v] && mMask[v]) ack = 1'b0;
      applyStimulus(r, irq, ($urandom_range(0, 15) == 0), 8'($urandom),
                    ($urandom_range(0, 4) == 0), ack, v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
